// File: rtl/output_stream_buffer.sv
// output_stream_buffer
//
// Purpose: takes finished output pixels from the convolution controller and
// re-emits them on a valid/ready stream toward the host. Each pixel is an
// accumulator value plus its x, y and channel tags. The controller cannot be
// stalled, so bursts are absorbed in a small circular FIFO. A result that
// arrives while the FIFO is full and nothing is being popped is dropped, and
// the sticky overflow flag is set. Popped outputs are counted, and done is
// raised once a full layer (W*H*OUT_CH outputs) has been delivered.
//
// Optional feature macro: OUTBUF_RELU_EN
//   When defined, negative input data (MSB set) is stored as zero, which
//   applies a ReLU. The tags are never modified.
//   When not defined, data is stored bit-exact.
//
// Ports:
//   clk                      rising-edge clock for all state
//   arst_in                  asynchronous reset, active-high
//   clear                    synchronous flush of FIFO, counter and flags
//   in_valid                 one-cycle strobe: a new result is present
//   in_data/in_x/in_y/in_ch  result value and tags
//   out_valid                head entry available
//   out_ready                consumer accepts the head entry
//   out_data/out_x/out_y/out_ch  head entry value and tags
//   level                    current occupancy, 0..FIFO_DEPTH
//   overflow                 sticky: at least one result was dropped
//   done                     sticky: the whole layer has been delivered
module output_stream_buffer #(
  parameter int DATA_WIDTH         = 32,
  parameter int COORD_WIDTH        = 32,
  parameter int FIFO_DEPTH         = 4,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64
) (
  input  logic                            clk,
  input  logic                            arst_in,
  input  logic                            clear,
  input  logic                            in_valid,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic [COORD_WIDTH-1:0]          in_x,
  input  logic [COORD_WIDTH-1:0]          in_y,
  input  logic [COORD_WIDTH-1:0]          in_ch,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [COORD_WIDTH-1:0]          out_x,
  output logic [COORD_WIDTH-1:0]          out_y,
  output logic [COORD_WIDTH-1:0]          out_ch,
  output logic [$clog2(FIFO_DEPTH):0]     level,
  output logic                            overflow,
  output logic                            done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [31:0] TOTAL =
    32'(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fill_t;

  logic [DATA_WIDTH-1:0]  mem_data [FIFO_DEPTH];
  logic [COORD_WIDTH-1:0] mem_x    [FIFO_DEPTH];
  logic [COORD_WIDTH-1:0] mem_y    [FIFO_DEPTH];
  logic [COORD_WIDTH-1:0] mem_ch   [FIFO_DEPTH];

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [31:0]           delivered;
  fill_t                 fill;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] store_data;

  // The fill state is a view of level and needs no storage of its own.
  always_comb begin
    fill = PARTIAL;
    if (level == '0)
      fill = EMPTY;
    else if (level == LW'(FIFO_DEPTH))
      fill = FULL;
  end

  // clear wins over both handshakes. A full FIFO still accepts a push when
  // the head leaves in the same cycle.
  assign out_valid = (fill != EMPTY);
  assign pop       = out_valid && out_ready && !clear;
  assign push      = in_valid && !clear && (fill != FULL || pop);

  always_comb begin
`ifdef OUTBUF_RELU_EN
    store_data = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
    store_data = in_data;
`endif
  end

  // Storage is not reset: only the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= store_data;
      mem_x[wr_ptr]    <= in_x;
      mem_y[wr_ptr]    <= in_y;
      mem_ch[wr_ptr]   <= in_ch;
    end
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
      delivered <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
      delivered <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        level <= level + 1'b1;
      else if (pop && !push)
        level <= level - 1'b1;
      if (in_valid && !push)
        overflow <= 1'b1;
      // The counter freezes once the layer is complete. Later pops still
      // drain the FIFO.
      if (pop && !done) begin
        delivered <= delivered + 32'd1;
        if (delivered + 32'd1 == TOTAL)
          done <= 1'b1;
      end
    end
  end

  // The head is read from registered storage and gated to zero while the
  // FIFO is empty. The outputs therefore read zero after reset, and nothing
  // from in_* or out_ready reaches them.
  always_comb begin
    out_data = '0;
    out_x    = '0;
    out_y    = '0;
    out_ch   = '0;
    if (out_valid) begin
      out_data = mem_data[rd_ptr];
      out_x    = mem_x[rd_ptr];
      out_y    = mem_y[rd_ptr];
      out_ch   = mem_ch[rd_ptr];
    end
  end

endmodule

// File: tb/tb_output_stream_buffer.sv
// tb_output_stream_buffer
//
// Drives output_stream_buffer (W=H=2, OUT_CH=1, depth 4) with directed
// scenarios followed by randomized traffic. A reference model tracks FIFO
// occupancy, the flags and the delivered count. It also queues every
// accepted result. A negedge monitor compares the DUT against that model.
module tb_output_stream_buffer;

  localparam int DW    = 32;
  localparam int CW    = 32;
  localparam int DEPTH = 4;
  localparam int TOTAL = 4;

  typedef struct {
    logic [31:0] d;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ch;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_x = '0;
  logic [CW-1:0] in_y = '0;
  logic [CW-1:0] in_ch = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_x;
  logic [CW-1:0] out_y;
  logic [CW-1:0] out_ch;
  logic [2:0]    level;
  logic          overflow;
  logic          done;

  ent_t exp_q[$];
  int   m_level = 0;
  int   m_deliv = 0;
  bit   m_over = 1'b0;
  bit   m_done = 1'b0;
  bit   m_pop;
  bit   m_push;
  ent_t m_ent;
  ent_t head;

  int n_checks = 0;
  int n_pass = 0;

  output_stream_buffer #(
    .DATA_WIDTH(DW),
    .COORD_WIDTH(CW),
    .FIFO_DEPTH(DEPTH),
    .FEATURE_MAP_WIDTH(2),
    .FEATURE_MAP_HEIGHT(2),
    .OUTPUT_NB_CHANNELS(1)
  ) dut (
    .clk(clk),
    .arst_in(rst),
    .clear(clear),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_x(in_x),
    .in_y(in_y),
    .in_ch(in_ch),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_x(out_x),
    .out_y(out_y),
    .out_ch(out_ch),
    .level(level),
    .overflow(overflow),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t",
               name, act, exp, $time);
  endtask

  // The stored value is the input data after the optional ReLU is applied.
  function automatic logic [31:0] storedValue(input logic [31:0] d);
`ifdef OUTBUF_RELU_EN
    return d[31] ? 32'd0 : d;
`else
    return d;
`endif
  endfunction

  // The reference model works on FIFO semantics: an occupancy count, a
  // queue of accepted results and the sticky flags.
  always @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      exp_q.delete();
      m_level = 0;
      m_deliv = 0;
      m_over  = 1'b0;
      m_done  = 1'b0;
    end else begin
      m_pop  = (m_level > 0) && out_ready;
      m_push = in_valid && ((m_level < DEPTH) || m_pop);
      if (m_pop) begin
        m_level = m_level - 1;
        if (m_deliv < TOTAL) begin
          m_deliv = m_deliv + 1;
          if (m_deliv == TOTAL)
            m_done = 1'b1;
        end
      end
      if (m_push) begin
        m_ent.d  = storedValue(in_data);
        m_ent.x  = in_x;
        m_ent.y  = in_y;
        m_ent.ch = in_ch;
        exp_q.push_back(m_ent);
        m_level = m_level + 1;
      end else if (in_valid) begin
        m_over = 1'b1;
      end
    end
  end

  // The monitor samples on the falling edge. Each time the DUT presents a
  // head, it is compared against the oldest accepted result. That result is
  // retired when out_ready completes the handshake.
  always @(negedge clk) begin
    checkOutput("out_valid", 64'(out_valid), 64'(m_level != 0));
    checkOutput("level", 64'(level), 64'(m_level));
    checkOutput("overflow", 64'(overflow), 64'(m_over));
    checkOutput("done", 64'(done), 64'(m_done));
    checkOutput("delivered", 64'(dut.delivered), 64'(m_deliv));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL head_present actual=valid expected=empty at %0t",
                 $time);
      end else begin
        head = exp_q[0];
        checkOutput("out_data", 64'(out_data), 64'(head.d));
        checkOutput("out_x", 64'(out_x), 64'(head.x));
        checkOutput("out_y", 64'(out_y), 64'(head.y));
        checkOutput("out_ch", 64'(out_ch), 64'(head.ch));
        if (out_ready)
          void'(exp_q.pop_front());
      end
    end
  end

  // Each call drives one cycle of inputs just after a rising edge. The DUT
  // samples them on the following edge.
  task automatic applyStimulus(input logic v, input logic [31:0] d,
                               input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] ch, input logic rdy,
                               input logic clr);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    in_x      = x;
    in_y      = y;
    in_ch     = ch;
    out_ready = rdy;
    clear     = clr;
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_data", 64'(out_data), 64'd0);
    checkOutput("reset_out_x", 64'(out_x), 64'd0);
    checkOutput("reset_level", 64'(level), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single result, consumed immediately.
    applyStimulus(1, 32'h0000_0123, 5, 7, 2, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    checkOutput("single_level", 64'(level), 64'd0);

    // Burst of six with no consumer: four are kept, two are dropped.
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 32'h100 + 32'(i), 32'(i), 32'(i + 10), 32'(i + 20), 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("burst_level", 64'(level), 64'd4);
    checkOutput("burst_overflow", 64'(overflow), 64'd1);
    checkOutput("burst_head", 64'(out_data), 64'h100);
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 1, 0);

    // Full FIFO with a simultaneous push and pop: nothing is dropped.
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 32'h200 + 32'(i), 32'(i), 0, 0, 0, 0);
    applyStimulus(1, 32'h2AA, 9, 9, 9, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("full_pushpop_level", 64'(level), 64'd4);
    checkOutput("full_pushpop_overflow", 64'(overflow), 64'd0);

    // Drain five in total: done rises after the fourth delivery and the
    // counter then stays at four.
    repeat (5) applyStimulus(0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("layer_done", 64'(done), 64'd1);
    checkOutput("delivered_saturated", 64'(dut.delivered), 64'd4);

    // Negative accumulator value.
    applyStimulus(1, 32'hFFFF_FFF0, 1, 2, 3, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
`ifdef OUTBUF_RELU_EN
    checkOutput("relu_data", 64'(out_data), 64'd0);
`else
    checkOutput("raw_neg_data", 64'(out_data), 64'hFFFF_FFF0);
`endif
    applyStimulus(0, 0, 0, 0, 0, 1, 0);

    // Asynchronous reset while three entries are held.
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 32'h300 + 32'(i), 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_level", 64'(level), 64'd0);
    checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Clear with two entries held and a new result arriving in the same cycle.
    for (int i = 0; i < 2; i++)
      applyStimulus(1, 32'h400 + 32'(i), 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h4FF, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("clear_level", 64'(level), 64'd0);
    checkOutput("clear_out_valid", 64'(out_valid), 64'd0);
    checkOutput("clear_overflow", 64'(overflow), 64'd0);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 1),
                    $urandom_range(0, 1), 0, 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 63) == 0));
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    repeat (6) @(posedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
